// File: rtl/fused_seq_pkg.sv
// Shared types for the fused-layer sequencer: per-layer config record and FSM states.
package fused_seq_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DIM_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] ifm_base;
    logic [ADDR_W-1:0] ifm_size;
    logic [ADDR_W-1:0] w1_base;
    logic [ADDR_W-1:0] w1_size;
    logic [ADDR_W-1:0] w2_base;
    logic [ADDR_W-1:0] w2_size;
    logic [DIM_W-1:0]  kernel_w;
    logic [DIM_W-1:0]  ofm_w;
    logic [DIM_W-1:0]  ofm_c;
    logic [DIM_W-1:0]  ifm_c;
    logic [DIM_W-1:0]  ifm_w;
    logic [DIM_W-1:0]  stride;
    logic [DIM_W-1:0]  ifm_c_l2;
    logic [DIM_W-1:0]  ofm_c_l2;
    logic [DIM_W-1:0]  ofm_w_l2;
  } cfg_t;

  localparam int unsigned CFG_W = $bits(cfg_t);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN, DONE} state_e;

endpackage

// File: rtl/fused_layer_sequencer_if.sv
// OFM word stream from the sequencer FIFO to its consumer (valid/ready).
interface fused_layer_sequencer_if #(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned NUM_LAYERS = 4
);
  logic                          ofm_valid;
  logic                          ofm_ready;
  logic [NUM_PE*8-1:0]           ofm_data;
  logic [$clog2(NUM_LAYERS)-1:0] ofm_layer;

  modport master (output ofm_valid, output ofm_data, output ofm_layer, input ofm_ready);
  modport slave  (input ofm_valid, input ofm_data, input ofm_layer, output ofm_ready);
endinterface

// File: rtl/seq_ofm_fifo.sv
// First-word-fall-through sync FIFO; pointers carry one wrap bit to tell full from empty.
module seq_ofm_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_valid_c,
  output logic             o_full_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_valid_c = (r_wr_ptr != r_rd_ptr);
  assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && o_valid_c;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = i_push && (!o_full_c || w_do_pop);
  assign o_rdata_c = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/fused_layer_sequencer.sv
// Walks a per-layer config table, pulsing the fused core once per layer and
// queueing per-PE OFM bytes (tagged with their layer) for a downstream consumer.
module fused_layer_sequencer
  import fused_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0] cfg_idx,
  input  cfg_t                          cfg_wdata,
  input  logic [$clog2(NUM_LAYERS):0]   num_layers,
  input  logic                          start,
  input  logic                          abort,
  output cfg_t                          layer_cfg,
  output logic                          core_start,
  input  logic                          core_done,
  input  logic [NUM_PE-1:0]             pe_finish,
  input  logic [NUM_PE*8-1:0]           pe_ofm,
  fused_layer_sequencer_if.master       ofm_if,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
  output logic                          overflow
);
  localparam int unsigned LW = $clog2(NUM_LAYERS);
  localparam int unsigned NW = LW + 1;
  localparam int unsigned FW = NUM_PE*8 + LW;

  state_e          r_state;
  cfg_t            r_table [NUM_LAYERS];
  cfg_t            r_layer_cfg;
  logic            r_core_start;
  logic            r_busy;
  logic            r_done;
  logic            r_overflow;
  logic [LW-1:0]   r_cur_layer;
  logic [LW-1:0]   r_last_layer;

  logic            w_capture;
  logic            w_valid;
  logic            w_full;
  logic            w_drop;
  logic [FW-1:0]   w_rdata;
  logic [LW-1:0]   w_last_c;

  // Oversized layer counts saturate to the full table.
  assign w_last_c  = (num_layers >= NW'(NUM_LAYERS)) ? LW'(NUM_LAYERS - 1)
                                                      : LW'(num_layers - NW'(1));
  assign w_capture = ((r_state == RUN) || (r_state == DRAIN)) && (&pe_finish) && !abort;
  assign w_drop    = w_capture && w_full && !(w_valid && ofm_if.ofm_ready);

  seq_ofm_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (abort),
    .i_push    (w_capture),
    .i_pop     (ofm_if.ofm_ready),
    .i_wdata   ({pe_ofm, r_cur_layer}),
    .o_rdata_c (w_rdata),
    .o_valid_c (w_valid),
    .o_full_c  (w_full)
  );

  assign ofm_if.ofm_valid = w_valid;
  assign ofm_if.ofm_data  = w_rdata[FW-1:LW];
  assign ofm_if.ofm_layer = w_rdata[LW-1:0];

  always_ff @(posedge clk) begin
    if (cfg_we && (r_state == IDLE) && !abort) r_table[cfg_idx] <= cfg_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_layer_cfg  <= '0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_cur_layer  <= '0;
      r_last_layer <= '0;
    end else begin
      r_core_start <= 1'b0;
      r_done       <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      if (abort) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_cur_layer <= '0;
      end else begin
        unique case (r_state)
          IDLE: if (start) begin
            if (num_layers == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy       <= 1'b1;
              r_cur_layer  <= '0;
              r_last_layer <= w_last_c;
              r_state      <= LOAD;
            end
          end
          LOAD: begin
            r_layer_cfg  <= r_table[r_cur_layer];
            r_core_start <= 1'b1;
            r_state      <= START;
          end
          START: r_state <= RUN;
          RUN:   if (core_done) r_state <= DRAIN;
          DRAIN: if (!w_valid) begin
            if (r_cur_layer == r_last_layer) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_cur_layer <= r_cur_layer + LW'(1);
              r_state     <= LOAD;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign layer_cfg  = r_layer_cfg;
  assign core_start = r_core_start;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cur_layer  = r_cur_layer;
  assign overflow   = r_overflow;

endmodule

// File: doc/fused_layer_sequencer.md
Name: fused_layer_sequencer

Overview:
- Parametrised multi-layer controller for the fused-block CNN top.
- Holds a per-layer configuration table and drives layer config plus a start pulse into the fused core, layer after layer, without testbench intervention.
- Captures per-PE OFM bytes into a packed-word FIFO with a valid/ready output.
- Replaces hand-sequenced layer-2 restarts with a hardware chain of up to NUM_LAYERS fused blocks.

Parameters:
- NUM_LAYERS, 4: config table depth (max layers per run); power of two.
- NUM_PE, 4: PE lanes captured per OFM event.
- FIFO_DEPTH, 8: OFM word FIFO entries; power of two, ≥2.
- ADDR_W, 32: address/size field width.
- DIM_W, 8: dimension/channel field width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cfg_we  in  1  write config entry.
- cfg_idx  in  $clog2(NUM_LAYERS)  entry index.
- cfg_wdata  in  $bits(cfg_t)  layer config: IFM/W1/W2 base+size, KERNEL_W, OFM_W, OFM_C, IFM_C, IFM_W, stride, IFM_C_layer2, OFM_C_layer2, OFM_W_layer2.
- num_layers  in  $clog2(NUM_LAYERS)+1  layers to run.
- start  in  1  run request pulse.
- abort  in  1  synchronous abort.
- layer_cfg  out  $bits(cfg_t)  registered config to core.
- core_start  out  1  one-cycle start pulse to core.
- core_done  in  1  core done_compute.
- pe_finish  in  NUM_PE  per-PE finish flags.
- pe_ofm  in  NUM_PE*8  per-PE OFM bytes, PE0 in LSBs.
- ofm_valid  out  1  FIFO head valid.
- ofm_ready  in  1  consumer accept.
- ofm_data  out  NUM_PE*8  packed OFM word.
- ofm_layer  out  $clog2(NUM_LAYERS)  layer tag of head word.
- busy  out  1  run in progress.
- done  out  1  one-cycle run complete.
- cur_layer  out  $clog2(NUM_LAYERS)  active layer.
- overflow  out  1  sticky; capture dropped on full FIFO.

Behaviour:
- Reset: state IDLE; layer_cfg, core_start, busy, done, cur_layer, overflow, ofm_valid all 0; FIFO empty; config table contents undefined (not reset).
- Config table: written when cfg_we=1 and state==IDLE; writes while busy are ignored.
- Start/abort gating: start is ignored while busy. abort has priority over every other event in all states: go to IDLE, flush FIFO, deassert busy; no done pulse; overflow unchanged.
- State machine:
  - IDLE: start with num_layers==0 → done=1 next cycle, stays IDLE. start with num_layers>NUM_LAYERS → treated as NUM_LAYERS. Otherwise busy=1, cur_layer=0 → LOAD.
  - LOAD: layer_cfg <= table[cur_layer] → START.
  - START: core_start=1 for exactly this cycle → RUN.
  - RUN: wait for core_done → DRAIN.
  - DRAIN: wait for FIFO empty. Then, if cur_layer==num_layers-1 → DONE; else cur_layer+1 → LOAD.
  - DONE: done=1 one cycle, busy=0 → IDLE.
- Latency: start sampled at edge T gives core_start high in cycle T+2. Each layer boundary costs 2 cycles (LOAD, START) after the FIFO drains.
- Capture event: in RUN or DRAIN, when &pe_finish==1. Sampled every cycle the condition holds (level, not edge). Pushes {pe_ofm, cur_layer}.
  - Full FIFO without a pop in the same cycle: word dropped, overflow set sticky until reset.
  - Simultaneous push/pop on full FIFO: both succeed.
  - Capture and core_done in the same cycle: word captured, then DRAIN.
- FIFO: first-word-fall-through. A push into an empty FIFO gives ofm_valid=1 on the next cycle. Pop when ofm_valid&ofm_ready. ofm_data and ofm_layer are stable while ofm_valid&!ofm_ready. Pointers wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.
- core_done outside RUN is ignored.

Decomposition:
- Package fused_seq_pkg: cfg_t packed struct (field order as listed for cfg_wdata, MSB first), state_e enum {IDLE, LOAD, START, RUN, DRAIN, DONE}, and a localparam for the cfg_t width.
- One sub-module: seq_ofm_fifo (parametrised sync FWFT FIFO, width NUM_PE*8+$clog2(NUM_LAYERS), depth FIFO_DEPTH). It shares clk/reset and has its own flush input driven by abort.

Test Plan:
- Write entry 0 {size_IFM=0x32C40, OFM_C=64, IFM_C=16, IFM_W=114, stride=2}, num_layers=1, start at T → layer_cfg matches at T+2, core_start high only at T+2; core_done at T+20 → done pulse once FIFO empty, busy falls with it.
- Two layers (entry 1 OFM_C=128, IFM_W=56); 3 capture events per layer with pe_ofm=0x44332211 → 6 words in order, ofm_layer 0,0,0,1,1,1; second core_start exactly 2 cycles after FIFO drains.
- Backpressure: ofm_ready=0, FIFO_DEPTH+2 captures → FIFO_DEPTH words retained, overflow=1, then release → FIFO_DEPTH words emitted unchanged.
- abort during RUN with 3 words queued → IDLE next cycle, ofm_valid=0, no done, busy=0; a new start runs cleanly.
- Edge cases: start with num_layers=0 → done after 1 cycle, no core_start; start while busy and cfg_we while busy → no effect (table readback on the next run shows old values).
- Assert reset mid-RUN → all outputs 0 immediately (asynchronous), FIFO empty, overflow cleared.
